// File: rtl/slip_pkg.sv
// Shared SLIP constants, encoder state type and escape helpers.
package slip_pkg;

  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_ESC2,
    S_END
  } slip_tx_st_t;

  function automatic logic slip_needs_esc(input logic [7:0] b);
    return (b == SLIP_END) || (b == SLIP_ESC);
  endfunction

  // Second byte of an escape pair; only meaningful when slip_needs_esc(b).
  function automatic logic [7:0] slip_esc_second(input logic [7:0] b);
    return (b == SLIP_END) ? SLIP_ESC_END : SLIP_ESC_ESC;
  endfunction

endpackage

// File: rtl/slip_fifo.sv
// Synchronous FIFO with combinational head read and occupancy count.
module slip_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/slip_tx_stream.sv
// SLIP frame encoder: buffers {last, byte} in a FIFO and streams escaped,
// END-delimited frames through a registered valid/ready output.
module slip_tx_stream
  import slip_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter bit          LEAD_END = 1'b1,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned LW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    fifo_level,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  slip_tx_st_t      state_q, state_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       esc2_q, esc2_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic [8:0]       head;
  logic [7:0]       head_data;
  logic             head_last;
  logic             slot_free;
  logic             take_data;

  slip_fifo #(
    .WIDTH (9),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata ({in_last, in_data}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign {head_last, head_data} = head;
  assign slot_free = !out_valid_q || out_ready;

  // Cycles that consume the FIFO head; without a leading END, idle acts as data.
  assign take_data = slot_free && !fifo_empty &&
                     ((state_q == S_DATA) || ((state_q == S_IDLE) && !LEAD_END));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (take_data) begin
      if (slip_needs_esc(head_data)) begin
        state_d = S_ESC2;
      end else begin
        state_d = head_last ? S_END : S_DATA;
      end
    end else if (slot_free) begin
      unique case (state_q)
        S_IDLE:  if (!fifo_empty) state_d = S_DATA;
        S_ESC2:  state_d = last_q ? S_END : S_DATA;
        S_END:   state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    esc2_d      = esc2_q;
    last_d      = last_q;
    frame_cnt_d = frame_cnt_q;
    pop         = 1'b0;
    // An accepted byte leaves the register unless something replaces it.
    if (slot_free) out_valid_d = 1'b0;
    if (take_data) begin
      pop         = 1'b1;
      out_valid_d = 1'b1;
      last_d      = head_last;
      if (slip_needs_esc(head_data)) begin
        out_data_d = SLIP_ESC;
        esc2_d     = slip_esc_second(head_data);
      end else begin
        out_data_d = head_data;
      end
    end else if (slot_free) begin
      unique case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            out_data_d  = SLIP_END;
            out_valid_d = 1'b1;
          end
        end
        S_ESC2: begin
          out_data_d  = esc2_q;
          out_valid_d = 1'b1;
        end
        S_END: begin
          out_data_d  = SLIP_END;
          out_valid_d = 1'b1;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      esc2_q      <= 8'h00;
      last_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      esc2_q      <= esc2_d;
      last_q      <= last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign in_ready  = !fifo_full;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q != S_IDLE) || !fifo_empty || out_valid_q;

endmodule

// File: tb/tb_slip_tx_stream.sv
// Bench for slip_tx_stream: directed scenarios plus randomized frames checked
// against a byte-level SLIP encoding model, on two parameterizations.
module tb_slip_tx_stream;
  import slip_pkg::*;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic [7:0] in_data   = 8'h00;
  logic       in_last   = 1'b0;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;
  logic       sel       = 1'b1;

  always #5 clk = ~clk;

  logic        iv0, iv1, rdy0, rdy1, ov0, ov1, bsy0, bsy1;
  logic [7:0]  od0, od1;
  logic [4:0]  lvl0;
  logic [2:0]  lvl1;
  logic [15:0] fc0;
  logic [7:0]  fc1;

  assign iv0 = in_valid & ~sel;
  assign iv1 = in_valid & sel;

  // dut0: no leading END, deep FIFO.
  slip_tx_stream #(.DEPTH(16), .LEAD_END(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(iv0),
    .in_ready(rdy0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
    .fifo_level(lvl0), .busy(bsy0), .frame_cnt(fc0)
  );

  // dut1: leading END, 4-entry FIFO, 8-bit frame counter.
  slip_tx_stream #(.DEPTH(4), .LEAD_END(1'b1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(iv1),
    .in_ready(rdy1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
    .fifo_level(lvl1), .busy(bsy1), .frame_cnt(fc1)
  );

  logic       rdy, ov, bsy;
  logic [7:0] od;
  int         lvl, fcnt;

  always_comb begin
    rdy  = sel ? rdy1 : rdy0;
    ov   = sel ? ov1 : ov0;
    bsy  = sel ? bsy1 : bsy0;
    od   = sel ? od1 : od0;
    lvl  = sel ? int'(lvl1) : int'(lvl0);
    fcnt = sel ? int'(fc1) : int'(fc0);
  end

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] cap_d [32];
  logic       cap_v [32];
  int         cap_wait;
  int         cap_n;

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int k = 0;
    in_data = d; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    while (!rdy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!rdy) begin
      n_vec++; n_err++;
      $display("FAIL push_timeout: in_ready=%b, required 1", rdy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // strict: n consecutive cycles from the first out_valid; else n accepted bytes.
  task automatic capture(input int n, input bit strict);
    int k = 0;
    cap_n = 0; cap_wait = 0;
    for (int i = 0; i < 32; i++) begin
      cap_v[i] = 1'b0; cap_d[i] = 8'h00;
    end
    if (strict) begin
      @(negedge clk);
      while (!ov && cap_wait < 40) begin
        @(negedge clk);
        cap_wait++;
      end
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(negedge clk);
        cap_v[i] = ov; cap_d[i] = od;
      end
      cap_n = n;
    end else begin
      while (cap_n < n && k < 200) begin
        @(negedge clk);
        k++;
        if (ov && out_ready) begin
          cap_v[cap_n] = 1'b1; cap_d[cap_n] = od; cap_n++;
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();
      @(negedge clk);
      n_vec++; if (ov !== 1'b0)  begin n_err++; $display("FAIL reset_out_valid%0d: got %b want 0", s, ov); end
      n_vec++; if (od !== 8'h00) begin n_err++; $display("FAIL reset_out_data%0d: got %02h want 00", s, od); end
      n_vec++; if (lvl !== 0)    begin n_err++; $display("FAIL reset_level%0d: got %0d want 0", s, lvl); end
      n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL reset_in_ready%0d: got %b want 1", s, rdy); end
      n_vec++; if (fcnt !== 0)   begin n_err++; $display("FAIL reset_frame_cnt%0d: got %0d want 0", s, fcnt); end
      n_vec++; if (bsy !== 1'b0) begin n_err++; $display("FAIL reset_busy%0d: got %b want 0", s, bsy); end
    end
  endtask

  task automatic test_basic();
    logic [7:0] want [4];
    want = '{8'hC0, 8'h01, 8'h02, 8'hC0};
    sel = 1'b1;
    do_reset();
    out_ready = 1'b1;
    fork
      begin push(8'h01, 1'b0); push(8'h02, 1'b1); end
      capture(4, 1'b1);
    join
    n_vec++;
    if (cap_wait !== 2) begin n_err++; $display("FAIL basic_latency: got %0d cycles want 2", cap_wait); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (cap_v[i] !== 1'b1 || cap_d[i] !== want[i]) begin
        n_err++;
        $display("FAIL basic_byte%0d: got v=%b d=%02h want v=1 d=%02h", i, cap_v[i], cap_d[i], want[i]);
      end
    end
    @(negedge clk);
    n_vec++; if (bsy !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %b want 0", bsy); end
    n_vec++; if (ov !== 1'b0)  begin n_err++; $display("FAIL basic_idle_valid: got %b want 0", ov); end
    n_vec++; if (fcnt !== 1)   begin n_err++; $display("FAIL basic_frame_cnt: got %0d want 1", fcnt); end
  endtask

  task automatic test_escape();
    logic [7:0] want [7];
    want = '{8'hC0, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'h55, 8'hC0};
    sel = 1'b1;
    do_reset();
    out_ready = 1'b1;
    fork
      begin push(8'hC0, 1'b0); push(8'hDB, 1'b0); push(8'h55, 1'b1); end
      capture(7, 1'b1);
    join
    for (int i = 0; i < 7; i++) begin
      n_vec++;
      if (cap_v[i] !== 1'b1 || cap_d[i] !== want[i]) begin
        n_err++;
        $display("FAIL escape_byte%0d: got v=%b d=%02h want v=1 d=%02h", i, cap_v[i], cap_d[i], want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [4];
    want = '{8'h10, 8'hC0, 8'h20, 8'hC0};
    sel = 1'b0;
    do_reset();
    out_ready = 1'b1;
    fork
      begin push(8'h10, 1'b1); push(8'h20, 1'b1); end
      capture(4, 1'b1);
    join
    n_vec++;
    if (cap_wait !== 2) begin n_err++; $display("FAIL b2b_latency: got %0d cycles want 2", cap_wait); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (cap_v[i] !== 1'b1 || cap_d[i] !== want[i]) begin
        n_err++;
        $display("FAIL b2b_byte%0d: got v=%b d=%02h want v=1 d=%02h", i, cap_v[i], cap_d[i], want[i]);
      end
    end
    @(negedge clk);
    n_vec++; if (fcnt !== 2) begin n_err++; $display("FAIL b2b_frame_cnt: got %0d want 2", fcnt); end
  endtask

  task automatic test_full();
    logic [7:0] want [8];
    want = '{8'hC0, 8'h11, 8'hDB, 8'hDC, 8'h22, 8'h33, 8'h44, 8'hC0};
    sel = 1'b1;
    do_reset();
    out_ready = 1'b0;
    push(8'h11, 1'b0); push(8'hC0, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0);
    in_data = 8'h44; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", rdy); end
    n_vec++; if (lvl !== 4)    begin n_err++; $display("FAIL full_level: got %0d want 4", lvl); end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (ov !== 1'b1 || od !== 8'hC0) begin
        n_err++;
        $display("FAIL full_stall%0d: got v=%b d=%02h want v=1 d=c0", i, ov, od);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    fork
      push(8'h44, 1'b1);
      capture(8, 1'b0);
    join
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (cap_v[i] !== 1'b1 || cap_d[i] !== want[i]) begin
        n_err++;
        $display("FAIL full_drain%0d: got v=%b d=%02h want v=1 d=%02h", i, cap_v[i], cap_d[i], want[i]);
      end
    end
    @(negedge clk);
    n_vec++; if (lvl !== 0)    begin n_err++; $display("FAIL full_level_end: got %0d want 0", lvl); end
    n_vec++; if (bsy !== 1'b0) begin n_err++; $display("FAIL full_busy_end: got %b want 0", bsy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] want [4];
    bit found = 1'b0;
    want = '{8'hC0, 8'hDB, 8'hDD, 8'hC0};
    sel = 1'b1;
    do_reset();
    out_ready = 1'b1;
    fork
      begin push(8'h05, 1'b1); push(8'hC0, 1'b0); push(8'h77, 1'b1); end
      begin
        for (int k = 0; k < 30 && !found; k++) begin
          @(negedge clk);
          if (ov && od == 8'hDB) found = 1'b1;
        end
      end
    join
    n_vec++; if (!found)     begin n_err++; $display("FAIL midrst_esc_seen: got 0 want 1"); end
    n_vec++; if (fcnt !== 1) begin n_err++; $display("FAIL midrst_cnt_before: got %0d want 1", fcnt); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_vec++; if (ov !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", ov); end
    n_vec++; if (lvl !== 0)   begin n_err++; $display("FAIL midrst_level: got %0d want 0", lvl); end
    n_vec++; if (fcnt !== 0)  begin n_err++; $display("FAIL midrst_frame_cnt: got %0d want 0", fcnt); end
    @(posedge clk); #1;
    fork
      push(8'hDB, 1'b1);
      capture(4, 1'b1);
    join
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (cap_v[i] !== 1'b1 || cap_d[i] !== want[i]) begin
        n_err++;
        $display("FAIL midrst_byte%0d: got v=%b d=%02h want v=1 d=%02h", i, cap_v[i], cap_d[i], want[i]);
      end
    end
  endtask

  task automatic test_random(input logic s, input bit lead, input int n_frames, input int cnt_mod);
    logic [8:0] in_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] d, held;
    int len, idx, guard, got, mcyc;
    bit pend;
    sel = s;
    do_reset();
    for (int f = 0; f < n_frames; f++) begin
      len = $urandom_range(1, 6);
      if (lead) exp_q.push_back(SLIP_END);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) == 1) ? SLIP_END : SLIP_ESC;
        else d = 8'($urandom_range(0, 255));
        in_q.push_back({(b == len - 1), d});
        if (d == SLIP_END) begin
          exp_q.push_back(SLIP_ESC); exp_q.push_back(SLIP_ESC_END);
        end else if (d == SLIP_ESC) begin
          exp_q.push_back(SLIP_ESC); exp_q.push_back(SLIP_ESC_ESC);
        end else begin
          exp_q.push_back(d);
        end
      end
      exp_q.push_back(SLIP_END);
    end
    idx = 0; guard = 0; got = 0; mcyc = 0; pend = 1'b0; held = 8'h00;
    fork
      begin
        while (idx < in_q.size() && guard < 60000) begin
          in_valid = ($urandom_range(0, 3) != 0);
          {in_last, in_data} = in_q[idx];
          @(negedge clk);
          if (in_valid && rdy) idx++;
          @(posedge clk); #1;
          guard++;
        end
        in_valid = 1'b0;
      end
      begin
        while (got < exp_q.size() && mcyc < 60000) begin
          out_ready = ($urandom_range(0, 1) == 1);
          @(negedge clk);
          if (pend) begin
            n_vec++;
            if (ov !== 1'b1 || od !== held) begin
              n_err++;
              $display("FAIL rand_stall: got v=%b d=%02h want v=1 d=%02h", ov, od, held);
            end
          end
          if (ov && out_ready) begin
            n_vec++;
            if (od !== exp_q[got]) begin
              n_err++;
              $display("FAIL rand_byte%0d: got %02h want %02h", got, od, exp_q[got]);
            end
            got++;
            pend = 1'b0;
          end else begin
            pend = ov; held = od;
          end
          @(posedge clk); #1;
          mcyc++;
        end
      end
    join
    out_ready = 1'b1;
    n_vec++;
    if (got != exp_q.size()) begin
      n_err++;
      $display("FAIL rand_timeout: got %0d bytes want %0d", got, exp_q.size());
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (fcnt !== n_frames % cnt_mod) begin
      n_err++;
      $display("FAIL rand_frame_cnt: got %0d want %0d", fcnt, n_frames % cnt_mod);
    end
    n_vec++; if (bsy !== 1'b0) begin n_err++; $display("FAIL rand_busy: got %b want 0", bsy); end
    n_vec++; if (ov !== 1'b0)  begin n_err++; $display("FAIL rand_extra_byte: got v=%b want 0", ov); end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_escape();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_random(1'b1, 1'b1, 1000, 256);
    test_random(1'b0, 1'b0, 300, 65536);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/slip_tx_stream.md
# slip_tx_stream

Parametrised SLIP (RFC 1055) frame encoder, successor to the single-byte encoder in the UART/SPI bridge datapath. Accepts a byte stream with an end-of-frame marker, buffers it in an internal FIFO, and emits escaped, END-delimited frames on a valid/ready byte port toward the UART transmitter. It adds configurable buffering, an optional leading END, back-to-back frame streaming, and frame/level status outputs.

## Interface
- DEPTH, 16: input FIFO entries; power of two, ≥ 2.
- LEAD_END, 1: 1 = emit END before each frame's first byte; 0 = trailing END only.
- CNT_W, 16: width of `frame_cnt`.
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  8  payload byte.
- in_last  in  1  marks the final byte of a frame; qualified by `in_valid`.
- in_valid  in  1  input byte valid.
- in_ready  out  1  FIFO can accept; `!full`.
- out_data  out  8  encoded byte (registered).
- out_valid  out  1  output byte valid (registered).
- out_ready  in  1  downstream accepts.
- fifo_level  out  $clog2(DEPTH+1)  current FIFO occupancy.
- busy  out  1  FSM not in S_IDLE, or FIFO non-empty, or `out_valid`.
- frame_cnt  out  CNT_W  frames whose trailing END has been loaded into the output register; wraps modulo 2^CNT_W.

## Operation
- Input handshake: push `{in_last, in_data}` when `in_valid && in_ready`. `in_ready` depends only on FIFO state, never on `in_valid`.
- Slot free: `!out_valid || out_ready`. The FSM loads `out_data` and asserts `out_valid` only when the slot is free. Otherwise `out_data` and `out_valid` hold.
- Escaping:
  - 0xC0 → 0xDB, 0xDC.
  - 0xDB → 0xDB, 0xDD.
  - All other bytes pass through unchanged.
- FSM states: S_IDLE, S_DATA, S_ESC2, S_END.
- S_IDLE, FIFO non-empty, slot free:
  - LEAD_END=1: emit 0xC0 with no pop, go to S_DATA.
  - LEAD_END=0: behave exactly as S_DATA does on this cycle.
- S_DATA, FIFO non-empty, slot free: pop the head.
  - Escapable byte: emit 0xDB, latch the second escape byte, go to S_ESC2.
  - Other byte: emit it; next state is S_END if the head's `last` is set, else S_DATA.
- S_ESC2, slot free: emit the latched second byte; go to S_END if the popped byte's `last` was set, else S_DATA.
- S_END, slot free: emit 0xC0, increment `frame_cnt`, go to S_IDLE.
- FIFO empty in S_DATA: wait. No filler bytes are emitted, and `out_valid` deasserts once the last byte is accepted.
- Only popped bytes are emitted. No byte is dropped or duplicated under any `out_ready` pattern.

## Timing
- Reset values (next edge after `rst` is high): `out_valid`=0, `out_data`=0x00, FIFO empty, `fifo_level`=0, `in_ready`=1, `frame_cnt`=0, `busy`=0, state S_IDLE.
- Reset mid-frame discards buffered and partially sent data; no END is emitted.
- Latency: input handshake at cycle 0 with an empty FIFO and S_IDLE gives the first output byte with `out_valid`=1 at cycle 2.
- Throughput: with `out_ready` held high, one encoded byte per cycle sustained, including escape pairs and END delimiters.
- Frame-to-frame turnaround: a frame's trailing END is immediately followed by the next frame's leading END (LEAD_END=1) or first byte, with no gap, when the FIFO is non-empty.
- Simultaneous push and pop: `fifo_level` is unchanged.
- Push when full: impossible, since `in_ready`=0.
- `fifo_level` updates the cycle after a push or pop.
- `frame_cnt` wraps from 2^CNT_W−1 to 0.

## Structure
- Package `slip_pkg`:
  - constants SLIP_END=8'hC0, SLIP_ESC=8'hDB, SLIP_ESC_END=8'hDC, SLIP_ESC_ESC=8'hDD;
  - the FSM state enum `slip_tx_st_t`.
- Sub-module `slip_fifo`: synchronous FIFO, parameters WIDTH=9 and DEPTH, with full/empty/level outputs. Non-registered read: the head is visible while non-empty.
- Encoder FSM and output register live in the top module.

## Test plan
- LEAD_END=1, frame {0x01, 0x02 last}, `out_ready`=1 → 0xC0, 0x01, 0x02, 0xC0; `frame_cnt`=1; `busy` falls after the last accept.
- Frame {0xC0, 0xDB, 0x55 last} → 0xC0, 0xDB, 0xDC, 0xDB, 0xDD, 0x55, 0xC0 on consecutive cycles.
- LEAD_END=0, two back-to-back frames {0x10 last}, {0x20 last} → 0x10, 0xC0, 0x20, 0xC0 with no idle cycle.
- DEPTH=4, `out_ready`=0, push 5 bytes:
  - after 4 pushes: `in_ready`=0 and `fifo_level`=4;
  - releasing `out_ready` drains everything in order, with `out_data` stable while stalled.
- Random `out_ready` and `in_valid` over 1000 random frames → decoded output equals input frames, no drops; `frame_cnt`=1000 mod 2^CNT_W.
- Assert `rst` mid-escape (after 0xDB emitted) → next cycle `out_valid`=0, `fifo_level`=0, `frame_cnt`=0; a new frame then encodes correctly.
